// File: rtl/mul_pkg.sv
// Shared types and defaults for the sequential shift-and-add multiplier.
package mul_pkg;
    localparam int MUL_N_DEFAULT = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mul_state_e;
endpackage

// File: rtl/shift_add_step.sv
// One shift-and-add iteration: conditional add of the multiplicand, then shift both operands.
module shift_add_step #(
    parameter int N = 16
) (
    input  logic [2*N-1:0] acc,
    input  logic [2*N-1:0] mcand,
    input  logic [N-1:0]   mplr,
    output logic [2*N-1:0] acc_nxt,
    output logic [2*N-1:0] mcand_nxt,
    output logic [N-1:0]   mplr_nxt
);
    // The full product fits in 2N bits, so the add never carries out.
    assign acc_nxt   = mplr[0] ? acc + mcand : acc;
    assign mcand_nxt = mcand << 1;
    assign mplr_nxt  = mplr >> 1;
endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned NxN multiplier, one bit of the multiplier per clock.
// Optional SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN finishes once the remaining multiplier bits are all zero.
module shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int N = MUL_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         req,
    input  logic [N-1:0] Multiplicand,
    input  logic [N-1:0] Multiplier,
    output logic [N-1:0] Hi,
    output logic [N-1:0] Lo,
    output logic         ready,
    output logic         exception
);
    localparam int CW = $clog2(N) + 1;

    mul_state_e      state;
    logic [2*N-1:0]  acc, mcand;
    logic [N-1:0]    mplr;
    logic [CW-1:0]   count;

    logic [2*N-1:0]  acc_nxt, mcand_nxt;
    logic [N-1:0]    mplr_nxt;
    logic            last;
    logic            zero_op;

    shift_add_step #(.N(N)) u_step (
        .acc       (acc),
        .mcand     (mcand),
        .mplr      (mplr),
        .acc_nxt   (acc_nxt),
        .mcand_nxt (mcand_nxt),
        .mplr_nxt  (mplr_nxt)
    );

    assign zero_op = (Multiplicand == '0) || (Multiplier == '0);

`ifdef SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN
    // No set bits left means every remaining iteration would add nothing.
    assign last = (mplr_nxt == '0) || (count == CW'(N - 1));
`else
    assign last = (count == CW'(N - 1));
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplr      <= '0;
            count     <= '0;
            Hi        <= '0;
            Lo        <= '0;
            ready     <= 1'b0;
            exception <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (zero_op) begin
                            Hi        <= '0;
                            Lo        <= '0;
                            exception <= 1'b0;
                            ready     <= 1'b1;
                        end else begin
                            mcand <= {{N{1'b0}}, Multiplicand};
                            mplr  <= Multiplier;
                            acc   <= '0;
                            count <= '0;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc   <= acc_nxt;
                    mcand <= mcand_nxt;
                    mplr  <= mplr_nxt;
                    count <= count + 1'b1;
                    if (last) begin
                        {Hi, Lo}  <= acc_nxt;
                        exception <= |acc_nxt[2*N-1:N];
                        ready     <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
